de2_115_sd_card_nios_key_debounce: RTL and testbench

DE2_115_SD_CARD_NIOS_KEY_DEBOUNCE -- requirements
Module: de2_115_sd_card_nios_key_debounce

---
 rtl/de2_115_sd_card_nios_key_debounce_pkg.sv | 13 +
 rtl/de2_115_sd_card_nios_key_debounce_cell.sv | 60 ++++++
 rtl/de2_115_sd_card_nios_key_debounce.sv | 48 ++++
 tb/tb_de2_115_sd_card_nios_key_debounce.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/de2_115_sd_card_nios_key_debounce_pkg.sv
// Shared NIOS-system constants used by the pushbutton debouncer.
//   NIOS_NUM_KEYS         number of board pushbuttons wired to the key PIO
//   NIOS_DEBOUNCE_CYCLES  stable cycles needed to accept a new level (1 ms @ 50 MHz)
//   NIOS_DEBOUNCE_CNT_W   counter width able to hold NIOS_DEBOUNCE_CYCLES-1
//   KEY_RELEASED          electrical level of a released (active-low) key
package de2_115_sd_card_nios_key_debounce_pkg;

    localparam int   NIOS_NUM_KEYS        = 4;
    localparam int   NIOS_DEBOUNCE_CYCLES = 50000;
    localparam int   NIOS_DEBOUNCE_CNT_W  = 20;
    localparam logic KEY_RELEASED         = 1'b1;

endpackage

// File: rtl/de2_115_sd_card_nios_key_debounce_cell.sv
// One debounce channel: two-flop synchronizer, stability counter, registered
// debounced level and one-cycle press/release pulses.
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   key_raw      raw active-low pushbutton, asynchronous to clk
//   key_out      debounced level (active-low)
//   key_press    one-cycle pulse when key_out falls 1->0
//   key_release  one-cycle pulse when key_out rises 0->1
module de2_115_sd_card_nios_key_debounce_cell
    import de2_115_sd_card_nios_key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = NIOS_DEBOUNCE_CYCLES,
    parameter int CNT_W           = NIOS_DEBOUNCE_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_out,
    output logic key_press,
    output logic key_release
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    // The counter only ever counts consecutive cycles in which sync disagrees
    // with key_out; any agreeing cycle throws the partial count away, and the
    // count is committed (not incremented) when it reaches CNT_LAST, so it can
    // never wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta   <= KEY_RELEASED;
            sync        <= KEY_RELEASED;
            key_out     <= KEY_RELEASED;
            cnt         <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync_meta   <= key_raw;
            sync        <= sync_meta;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            if (sync == key_out) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                key_out     <= sync;
                cnt         <= '0;
                // Pulse in the same cycle key_out takes its new value.
                key_press   <= ~sync;
                key_release <= sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/de2_115_sd_card_nios_key_debounce.sv
// Pushbutton debouncer for the DE2-115 SD-card NIOS system. key_out feeds the
// key PIO in_port directly; the press/release pulses are for optional fabric
// consumers. Every output comes straight from a register.
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   key_raw      [NUM_KEYS] raw active-low pushbuttons
//   key_out      [NUM_KEYS] debounced active-low levels
//   key_press    [NUM_KEYS] one-cycle pulse per bit on 1->0 of key_out
//   key_release  [NUM_KEYS] one-cycle pulse per bit on 0->1 of key_out
module de2_115_sd_card_nios_key_debounce
    import de2_115_sd_card_nios_key_debounce_pkg::*;
#(
    parameter int NUM_KEYS        = NIOS_NUM_KEYS,
    parameter int DEBOUNCE_CYCLES = NIOS_DEBOUNCE_CYCLES,
    parameter int CNT_W           = NIOS_DEBOUNCE_CNT_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_out,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    // Refuse to build with a counter that cannot reach DEBOUNCE_CYCLES-1 or
    // with a debounce length outside the supported range.
    if ((64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("CNT_W too small for DEBOUNCE_CYCLES");
    end
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_cycles
        $error("DEBOUNCE_CYCLES outside 2..2^20");
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        de2_115_sd_card_nios_key_debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_cell (
            .clk         (clk),
            .reset_n     (reset_n),
            .key_raw     (key_raw[i]),
            .key_out     (key_out[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i])
        );
    end

endmodule

// File: tb/tb_de2_115_sd_card_nios_key_debounce.sv
module tb_de2_115_sd_card_nios_key_debounce;

    localparam int NK  = 4;
    localparam int DC  = 8;
    localparam int CW  = 4;
    localparam int LAT = 2 + DC;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NK-1:0] key_raw;
    logic [NK-1:0] key_out, key_press, key_release;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    de2_115_sd_card_nios_key_debounce #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DC), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .key_raw(key_raw),
        .key_out(key_out), .key_press(key_press), .key_release(key_release)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a key's output flips once the synchronized input has
    // disagreed with it for DC consecutive samples.
    logic [NK-1:0] m_s1, m_s2, m_out, m_press, m_rel;
    int            streak [NK];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 <= '1; m_s2 <= '1; m_out <= '1; m_press <= '0; m_rel <= '0;
            for (int i = 0; i < NK; i++) streak[i] <= 0;
        end else begin
            m_s1 <= key_raw;
            m_s2 <= m_s1;
            for (int i = 0; i < NK; i++) begin
                m_press[i] <= 1'b0;
                m_rel[i]   <= 1'b0;
                if (m_s2[i] == m_out[i]) begin
                    streak[i] <= 0;
                end else if (streak[i] + 1 == DC) begin
                    streak[i]  <= 0;
                    m_out[i]   <= m_s2[i];
                    m_press[i] <= ~m_s2[i];
                    m_rel[i]   <= m_s2[i];
                end else begin
                    streak[i] <= streak[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_key_out", 32'(key_out), 32'(m_out));
            check("model_key_press", 32'(key_press), 32'(m_press));
            check("model_key_release", 32'(key_release), 32'(m_rel));
            check("press_release_exclusive", 32'(|(key_press & key_release)), 32'd0);
        end
    end

    // Accumulators sampled on negedges while holding a stimulus.
    logic [NK-1:0] acc_p, acc_r, acc_and;

    task automatic acc_clear();
        acc_p = '0; acc_r = '0; acc_and = '1;
    endtask

    // Called at a negedge: drive raw, then sit for n cycles accumulating.
    task automatic hold(input logic [NK-1:0] raw, input int n);
        key_raw = raw;
        repeat (n) begin
            @(negedge clk);
            acc_p   |= key_press;
            acc_r   |= key_release;
            acc_and &= key_out;
        end
    endtask

    typedef struct {
        logic [NK-1:0] raw;
        int            lat;
        logic [NK-1:0] out;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
    } vec_t;

    vec_t vecs [7];

    // Drive a new raw pattern and measure the cycles until key_out changes.
    task automatic run_vec(input int idx);
        logic [NK-1:0] prev, g_out, g_p, g_r;
        int n;
        bit found;
        @(negedge clk);
        prev = key_out;
        key_raw = vecs[idx].raw;
        n = 0; found = 0; g_out = prev; g_p = '0; g_r = '0;
        while (!found && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (key_out !== prev) begin
                found = 1; g_out = key_out; g_p = key_press; g_r = key_release;
            end
        end
        check($sformatf("vec%0d_latency", idx), found ? 32'(n) : 32'hFFFF_FFFF, 32'(vecs[idx].lat));
        check($sformatf("vec%0d_key_out", idx), 32'(g_out), 32'(vecs[idx].out));
        check($sformatf("vec%0d_press", idx), 32'(g_p), 32'(vecs[idx].press));
        check($sformatf("vec%0d_release", idx), 32'(g_r), 32'(vecs[idx].rel));
        @(posedge clk); #1;
        check($sformatf("vec%0d_pulse_one_cycle", idx), 32'(key_press | key_release), 32'd0);
    endtask

    initial begin
        int n;
        bit found;
        int pulse_cnt, trans_cnt;
        logic [NK-1:0] prev_out, r;

        vecs[0] = '{4'hE, LAT, 4'hE, 4'h1, 4'h0};
        vecs[1] = '{4'hF, LAT, 4'hF, 4'h0, 4'h1};
        vecs[2] = '{4'h0, LAT, 4'h0, 4'hF, 4'h0};
        vecs[3] = '{4'hF, LAT, 4'hF, 4'h0, 4'hF};
        vecs[4] = '{4'h5, LAT, 4'h5, 4'hA, 4'h0};
        vecs[5] = '{4'hA, LAT, 4'hA, 4'h5, 4'hA};
        vecs[6] = '{4'hF, LAT, 4'hF, 4'h0, 4'h5};

        reset_n = 1'b0;
        key_raw = 4'hF;
        repeat (3) @(negedge clk);
        check("reset_key_out", 32'(key_out), 32'hF);
        check("reset_key_press", 32'(key_press), 32'h0);
        check("reset_key_release", 32'(key_release), 32'h0);
        chk_en  = 1;
        reset_n = 1'b1;

        // Quiet release: no spurious pulses.
        acc_clear();
        hold(4'hF, 100);
        check("idle_key_out", 32'(acc_and), 32'hF);
        check("idle_no_press", 32'(acc_p), 32'h0);
        check("idle_no_release", 32'(acc_r), 32'h0);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Bounce on key 1: 7 low, 1 high, 7 low, then high -> never accepted.
        @(negedge clk);
        acc_clear();
        hold(4'hD, 7);
        hold(4'hF, 1);
        hold(4'hD, 7);
        hold(4'hF, 20);
        check("bounce_key_out1", 32'(acc_and[1]), 32'd1);
        check("bounce_no_press1", 32'(acc_p[1]), 32'd0);
        check("bounce_no_release1", 32'(acc_r[1]), 32'd0);

        // Reset mid-count on key 2 (count reaches 5 after 7 edges).
        acc_clear();
        hold(4'hB, 7);
        reset_n = 1'b0;
        hold(4'hB, 3);
        check("midreset_key_out", 32'(key_out), 32'hF);
        check("midreset_no_press2", 32'(acc_p[2]), 32'd0);
        check("midreset_no_release", 32'(acc_r), 32'd0);
        reset_n = 1'b1;
        n = 0; found = 0;
        while (!found && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (key_out[2] === 1'b0) found = 1;
        end
        check("postreset_latency", found ? 32'(n) : 32'hFFFF_FFFF, 32'(LAT));
        check("postreset_press2", 32'(key_press), 32'h4);
        @(negedge clk);
        hold(4'hF, 20);

        // Random bounce stress, 10% toggle probability per bit per cycle.
        pulse_cnt = 0; trans_cnt = 0;
        prev_out = key_out;
        r = 4'hF;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            pulse_cnt += $countones(key_press) + $countones(key_release);
            trans_cnt += $countones(key_out ^ prev_out);
            prev_out = key_out;
            for (int b = 0; b < NK; b++)
                if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
            key_raw = r;
        end
        key_raw = 4'hF;
        repeat (20) begin
            @(negedge clk);
            pulse_cnt += $countones(key_press) + $countones(key_release);
            trans_cnt += $countones(key_out ^ prev_out);
            prev_out = key_out;
        end
        check("stress_pulses_eq_transitions", 32'(pulse_cnt), 32'(trans_cnt));
        check("stress_final_key_out", 32'(key_out), 32'hF);

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
